// File: rtl/lemon_pkg.sv
// Shared LemonPC integer-pipeline constants and types.
// Source encodings index the write-back arbiter's request/grant vectors.
package lemon_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_writer_if.sv
// Write-back bundle: ALU/LSU result streams, decode issue/check ports and the
// register file write port. The master side drives results and queries.
interface regfile_writer_if
    import lemon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN
);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;

    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;

    logic [ADDR_WIDTH-1:0] chk_rs1;
    logic [ADDR_WIDTH-1:0] chk_rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_dataD;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_en, issue_rd, chk_rs1, chk_rs2,
        input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        input  rf_wen, rf_rd, rf_dataD
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_en, issue_rd, chk_rs1, chk_rs2,
        output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        output rf_wen, rf_rd, rf_dataD
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request is granted directly; on a tie the
// source that did not win the previous tie is granted and becomes the new "last".
module rr_arb2
    import lemon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (&req) begin
            gnt    = (last_q == SRC_LSU) ? 2'b01 : 2'b10;
            last_d = (last_q == SRC_LSU) ? SRC_ALU : SRC_LSU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Write-back initiator: arbitrates ALU/LSU results onto the single register file
// write port and tracks per-register pending writes for decode RAW stalls.
module regfile_writer
    import lemon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input logic             clk,
    input logic             rst_n,
    regfile_writer_if.slave bus
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [1:0]            req, gnt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_rd_q;
    logic [DATA_WIDTH-1:0] rf_data_q;

    logic [1:0]            cnt_q [NumRegs];
    logic [1:0]            cnt_d [NumRegs];
    logic                  issue_ready;
    logic                  issue_inc;

    assign req[SRC_ALU] = bus.alu_valid;
    assign req[SRC_LSU] = bus.lsu_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.alu_ready = gnt[SRC_ALU];
    assign bus.lsu_ready = gnt[SRC_LSU];
    assign accept        = |gnt;

    always_comb begin
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
        if (gnt[SRC_LSU]) begin
            sel_rd   = bus.lsu_rd;
            sel_data = bus.lsu_data;
        end
    end

    // x0 accepts still complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q  <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            rf_wen_q <= accept && (sel_rd != '0);
            if (accept) begin
                rf_rd_q   <= sel_rd;
                rf_data_q <= sel_data;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_dataD = rf_data_q;

    assign issue_ready     = (cnt_q[bus.issue_rd] != 2'd3);
    assign bus.issue_ready = issue_ready;
    assign issue_inc       = bus.issue_en && issue_ready && (bus.issue_rd != '0);

    // Retirement happens on the cycle rf_wen is high, so busy covers that cycle too.
    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            logic inc_i, dec_i;
            cnt_d[i] = cnt_q[i];
            inc_i    = issue_inc && (bus.issue_rd == ADDR_WIDTH'(i));
            dec_i    = rf_wen_q && (rf_rd_q == ADDR_WIDTH'(i));
            if (inc_i && !dec_i) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (dec_i && !inc_i && (cnt_q[i] != 2'd0)) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.rs1_busy = (cnt_q[bus.chk_rs1] != 2'd0);
    assign bus.rs2_busy = (cnt_q[bus.chk_rs2] != 2'd0);

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed vector table, reset corner case, then a
// randomized phase checked against a pending-count/round-robin reference model.
module tb_regfile_writer;
    import lemon_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_writer_if #(.ADDR_WIDTH(REG_ADDR_W), .DATA_WIDTH(XLEN)) bus ();

    regfile_writer #(.ADDR_WIDTH(REG_ADDR_W), .DATA_WIDTH(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic ie, input logic [4:0] ird,
                         input logic [4:0] c1, input logic [4:0] c2);
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ld;
        bus.issue_en  = ie;  bus.issue_rd = ird;
        bus.chk_rs1   = c1;  bus.chk_rs2  = c2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic        ie;  logic [4:0] ird; logic [4:0] c1; logic [4:0] c2;
        logic        ar;  logic lr; logic wen; logic [4:0] rd; logic [31:0] data;
        logic        ir;  logic b1; logic b2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int av, input int ard, input int ad,
                       input int lv, input int lrd, input int ld,
                       input int ie, input int ird, input int c1, input int c2,
                       input int ar, input int lr, input int wen, input int rd, input int data,
                       input int ir, input int b1, input int b2);
        vec_t v;
        v.av = 1'(av); v.ard = 5'(ard); v.ad = 32'(ad);
        v.lv = 1'(lv); v.lrd = 5'(lrd); v.ld = 32'(ld);
        v.ie = 1'(ie); v.ird = 5'(ird); v.c1 = 5'(c1); v.c2 = 5'(c2);
        v.ar = 1'(ar); v.lr = 1'(lr); v.wen = 1'(wen); v.rd = 5'(rd); v.data = 32'(data);
        v.ir = 1'(ir); v.b1 = 1'(b1); v.b2 = 1'(b2);
        vecs.push_back(v);
    endtask

    // Reference model state for the randomized phase.
    int     cnt   [32];
    int     avail [32];
    logic   last_lsu;
    rf_wr_t exp_wr;
    typedef struct { logic v; logic [4:0] rd; logic [31:0] d; } offer_t;
    offer_t alu_s, lsu_s;

    task automatic new_offer(inout offer_t s);
        int base;
        s.v  = 1'b1;
        s.d  = $urandom;
        s.rd = 5'd0;
        if ($urandom_range(0, 4) != 0) begin
            base = $urandom_range(0, 31);
            for (int k = 0; k < 32; k++) begin
                int r;
                r = (base + k) % 32;
                if (r != 0 && avail[r] > 0) begin
                    avail[r]--;
                    s.rd = 5'(r);
                    break;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // av ard ad | lv lrd ld | ie ird | c1 c2 || ar lr | wen rd data | ir b1 b2
        add(0, 0, 0,            0, 0, 0,    1, 5, 5, 0, 0, 0, 0, 0, 0,            1, 0, 0);
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,    0, 0, 5, 0, 1, 0, 0, 0, 0,            1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 0, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 0, 5, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0,            0, 0, 0,    1, 1, 1, 4, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0,            0, 0, 0,    1, 2, 1, 4, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    1, 3, 1, 4, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    1, 4, 1, 4, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0);
        add(1, 1, 32'hA1,       1, 3, 32'hC3, 0, 0, 1, 4, 1, 0, 0, 5, 32'hDEADBEEF, 1, 1, 1);
        add(1, 2, 32'hA2,       1, 3, 32'hC3, 0, 0, 1, 4, 0, 1, 1, 1, 32'hA1,       1, 1, 1);
        add(1, 2, 32'hA2,       1, 4, 32'hC4, 0, 0, 1, 4, 1, 0, 1, 3, 32'hC3,       1, 0, 1);
        add(0, 0, 0,            1, 4, 32'hC4, 0, 0, 2, 4, 0, 1, 1, 2, 32'hA2,       1, 1, 1);
        add(0, 0, 0,            0, 0, 0,    0, 0, 2, 4, 0, 0, 1, 4, 32'hC4,       1, 0, 1);
        add(1, 0, 32'h1234,     0, 0, 0,    1, 0, 0, 4, 1, 0, 0, 4, 32'hC4,       1, 0, 0);
        add(0, 0, 0,            0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 32'h1234,     1, 0, 0);
        add(0, 0, 0,            0, 0, 0,    1, 7, 7, 0, 0, 0, 0, 0, 32'h1234,     1, 0, 0);
        add(0, 0, 0,            0, 0, 0,    1, 7, 7, 0, 0, 0, 0, 0, 32'h1234,     1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    1, 7, 7, 0, 0, 0, 0, 0, 32'h1234,     1, 1, 0);
        add(1, 7, 32'h77,       0, 0, 0,    1, 7, 7, 0, 1, 0, 0, 0, 32'h1234,     0, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 7, 7, 0, 0, 0, 1, 7, 32'h77,       0, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 7, 7, 0, 0, 0, 0, 7, 32'h77,       1, 1, 0);
        add(1, 7, 32'h78,       0, 0, 0,    0, 7, 7, 0, 1, 0, 0, 7, 32'h77,       1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    1, 7, 7, 0, 0, 0, 1, 7, 32'h78,       1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 7, 7, 0, 0, 0, 0, 7, 32'h78,       1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    1, 7, 7, 0, 0, 0, 0, 7, 32'h78,       1, 1, 0);
        add(0, 0, 0,            0, 0, 0,    0, 7, 7, 0, 0, 0, 0, 7, 32'h78,       0, 1, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
                  vecs[i].ie, vecs[i].ird, vecs[i].c1, vecs[i].c2);
            #1;
            check($sformatf("row%0d alu_ready", i),   32'(bus.alu_ready),   32'(vecs[i].ar));
            check($sformatf("row%0d lsu_ready", i),   32'(bus.lsu_ready),   32'(vecs[i].lr));
            check($sformatf("row%0d rf_wen", i),      32'(bus.rf_wen),      32'(vecs[i].wen));
            check($sformatf("row%0d rf_rd", i),       32'(bus.rf_rd),       32'(vecs[i].rd));
            check($sformatf("row%0d rf_dataD", i),    bus.rf_dataD,         vecs[i].data);
            check($sformatf("row%0d issue_ready", i), 32'(bus.issue_ready), 32'(vecs[i].ir));
            check($sformatf("row%0d rs1_busy", i),    32'(bus.rs1_busy),    32'(vecs[i].b1));
            check($sformatf("row%0d rs2_busy", i),    32'(bus.rs2_busy),    32'(vecs[i].b2));
            next_cycle();
        end

        // Reset while a write is on the register file port and x7 is saturated.
        drive(1, 7, 32'h79, 0, 0, 0, 0, 7, 7, 0);
        #1 check("rst_pre alu_ready", 32'(bus.alu_ready), 32'd1);
        next_cycle();
        check("rst_pre rf_wen", 32'(bus.rf_wen), 32'd1);
        rst_n = 1'b0;
        drive(1, 0, 32'h55, 0, 0, 0, 0, 7, 7, 0);
        #1;
        check("rst rf_wen", 32'(bus.rf_wen), 32'd0);
        check("rst rf_rd", 32'(bus.rf_rd), 32'd0);
        check("rst rf_dataD", bus.rf_dataD, 32'd0);
        check("rst rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check("rst issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rst lsu_ready", 32'(bus.lsu_ready), 32'd0);
        next_cycle();
        check("rst held rf_wen", 32'(bus.rf_wen), 32'd0);
        rst_n = 1'b1;
        drive(1, 0, 32'h11, 1, 0, 32'h22, 0, 7, 7, 0);
        #1;
        check("post_rst tie alu_ready", 32'(bus.alu_ready), 32'd1);
        check("post_rst tie lsu_ready", 32'(bus.lsu_ready), 32'd0);
        next_cycle();
        drive(0, 0, 0, 1, 0, 32'h22, 0, 7, 7, 0);
        #1;
        check("post_rst lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check("post_rst x0 rf_wen", 32'(bus.rf_wen), 32'd0);
        check("post_rst rf_dataD", bus.rf_dataD, 32'h11);
        next_cycle();

        // Randomized phase against the reference model, from a fresh reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            cnt[r]   = 0;
            avail[r] = 0;
        end
        last_lsu = 1'b1;
        exp_wr   = '0;
        alu_s.v  = 1'b0; alu_s.rd = '0; alu_s.d = '0;
        lsu_s    = alu_s;

        for (int cyc = 0; cyc < 600; cyc++) begin
            logic       ie, ear, elr, eir, tie;
            logic [4:0] ird, c1, c2;
            rf_wr_t     nxt;
            if (!alu_s.v && $urandom_range(0, 1) == 0) new_offer(alu_s);
            if (!lsu_s.v && $urandom_range(0, 1) == 0) new_offer(lsu_s);
            ie  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 5));
            c1  = 5'($urandom_range(0, 5));
            c2  = 5'($urandom_range(0, 31));
            drive(alu_s.v, alu_s.rd, alu_s.d, lsu_s.v, lsu_s.rd, lsu_s.d, ie, ird, c1, c2);
            #1;

            tie = alu_s.v && lsu_s.v;
            ear = alu_s.v && (!lsu_s.v || last_lsu);
            elr = lsu_s.v && !ear;
            eir = (ird == 0) || (cnt[ird] < 3);
            check($sformatf("rnd%0d alu_ready", cyc),   32'(bus.alu_ready),   32'(ear));
            check($sformatf("rnd%0d lsu_ready", cyc),   32'(bus.lsu_ready),   32'(elr));
            check($sformatf("rnd%0d issue_ready", cyc), 32'(bus.issue_ready), 32'(eir));
            check($sformatf("rnd%0d rs1_busy", cyc),    32'(bus.rs1_busy),    32'(cnt[c1] > 0));
            check($sformatf("rnd%0d rs2_busy", cyc),    32'(bus.rs2_busy),    32'(cnt[c2] > 0));
            check($sformatf("rnd%0d rf_wen", cyc),      32'(bus.rf_wen),      32'(exp_wr.wen));
            check($sformatf("rnd%0d rf_rd", cyc),       32'(bus.rf_rd),       32'(exp_wr.rd));
            check($sformatf("rnd%0d rf_dataD", cyc),    bus.rf_dataD,         exp_wr.data);

            nxt = exp_wr;
            nxt.wen = 1'b0;
            if (ear) begin
                nxt = '{wen: (alu_s.rd != 0), rd: alu_s.rd, data: alu_s.d};
                alu_s.v = 1'b0;
            end else if (elr) begin
                nxt = '{wen: (lsu_s.rd != 0), rd: lsu_s.rd, data: lsu_s.d};
                lsu_s.v = 1'b0;
            end
            if (tie) last_lsu = elr;
            if (exp_wr.wen) begin
                assert (cnt[exp_wr.rd] > 0)
                else $error("retire of x%0d with no pending write", exp_wr.rd);
                cnt[exp_wr.rd]--;
            end
            if (ie && eir && ird != 0) begin
                cnt[ird]++;
                avail[ird]++;
            end
            exp_wr = nxt;
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
